// File: rtl/shift_ctrl_pkg.sv
// Shared types and width helpers for the shift-register load sequencer.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        WAIT  = 2'd3
    } state_t;

    // bit_cnt must hold WIDTH+1 when the parity bit is appended
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(width + 2);
    endfunction

    // Gap counter runs 0..GAP-1; keep at least one bit so GAP<=1 still elaborates
    function automatic int unsigned gap_width(input int unsigned gap);
        return (gap < 2) ? 1 : $clog2(gap);
    endfunction

endpackage

// File: rtl/shift_bit_counter.sv
// Clearable up-counter with a terminal-count flag against a programmable last value.
module shift_bit_counter #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] count,
    output logic         tc_c
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + W'(1);
        end
    end

    assign tc_c = (count == last);

endmodule

// File: rtl/shift_load_ctrl.sv
// Serialises a parallel word MSB-first into a DFF chain with shift-enable and done pulse.
// Optional even-parity trailer bit enabled by defining SHIFT_PARITY_EN.
module shift_load_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned GAP   = 0
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    input  logic [WIDTH-1:0]            in_data,
    output logic                        in_ready,
    output logic                        sr_d,
    output logic                        sr_en,
    output logic                        busy,
    output logic                        done,
    output logic [cnt_width(WIDTH)-1:0] bit_cnt
);

    localparam int unsigned CW = cnt_width(WIDTH);
    localparam int unsigned GW = gap_width(GAP);

    state_t           state;
    logic [WIDTH-1:0] shadow;
    logic             accept_c;
    logic             bit_inc_c;
    logic             bit_last_c;
    logic             gap_last_c;
`ifdef SHIFT_PARITY_EN
    logic             par;
`endif

    assign accept_c = in_valid & in_ready;

`ifdef SHIFT_PARITY_EN
    assign bit_inc_c = (state == SHIFT) || (state == PAR);
`else
    assign bit_inc_c = (state == SHIFT);
`endif

    shift_bit_counter #(.W(CW)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (accept_c),
        .inc   (bit_inc_c),
        .last  (CW'(WIDTH - 1)),
        .count (bit_cnt),
        .tc_c  (bit_last_c)
    );

    // Gap counter idles at zero and only runs while waiting out the inter-word gap
    if (GAP > 0) begin : g_gap
        logic [GW-1:0] gap_cnt_unused;

        shift_bit_counter #(.W(GW)) u_gap_cnt (
            .clk   (clk),
            .reset (reset),
            .clr   (state != WAIT),
            .inc   (state == WAIT),
            .last  (GW'(GAP - 1)),
            .count (gap_cnt_unused),
            .tc_c  (gap_last_c)
        );
    end else begin : g_no_gap
        assign gap_last_c = 1'b1;
    end

    // Controller: outputs are registered alongside the state they belong to
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            shadow   <= '0;
            done     <= 1'b0;
            in_ready <= 1'b1;
            sr_en    <= 1'b0;
            sr_d     <= 1'b0;
            busy     <= 1'b0;
`ifdef SHIFT_PARITY_EN
            par      <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_c) begin
                        shadow   <= in_data;
                        state    <= SHIFT;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        sr_en    <= 1'b1;
                        sr_d     <= in_data[WIDTH-1];
`ifdef SHIFT_PARITY_EN
                        par      <= ^in_data;
`endif
                    end
                end
                SHIFT: begin
                    shadow <= shadow << 1;
                    sr_d   <= shadow[WIDTH-2];
                    if (bit_last_c) begin
`ifdef SHIFT_PARITY_EN
                        state <= PAR;
                        sr_d  <= par;
`else
                        done  <= 1'b1;
                        sr_en <= 1'b0;
                        sr_d  <= 1'b0;
                        if (GAP == 0) begin
                            state    <= IDLE;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            state <= WAIT;
                        end
`endif
                    end
                end
`ifdef SHIFT_PARITY_EN
                PAR: begin
                    done  <= 1'b1;
                    sr_en <= 1'b0;
                    sr_d  <= 1'b0;
                    if (GAP == 0) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state <= WAIT;
                    end
                end
`endif
                WAIT: begin
                    if (gap_last_c) begin
                        state    <= IDLE;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Scoreboard bench for shift_load_ctrl: GAP=0 and GAP=3 instances each drive a 4-stage chain.
module tb_shift_load_ctrl;

`ifdef SHIFT_PARITY_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       v0 = 1'b0, v3 = 1'b0;
    logic [3:0] d0 = '0, d3 = '0;
    logic       rdy0, sd0, en0, busy0, done0;
    logic       rdy3, sd3, en3, busy3, done3;
    logic [2:0] cnt0, cnt3;
    logic [3:0] ch0 = '0, ch3 = '0;
    int         cyc = 0;

    always #5 clk = ~clk;

    shift_load_ctrl #(.WIDTH(4), .GAP(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
        .sr_d(sd0), .sr_en(en0), .busy(busy0), .done(done0), .bit_cnt(cnt0)
    );

    shift_load_ctrl #(.WIDTH(4), .GAP(3)) u_dut3 (
        .clk(clk), .reset(reset), .in_valid(v3), .in_data(d3), .in_ready(rdy3),
        .sr_d(sd3), .sr_en(en3), .busy(busy3), .done(done3), .bit_cnt(cnt3)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // The external DFF chains fed by each controller
    always @(posedge clk) if (en0) ch0 <= {ch0[2:0], sd0};
    always @(posedge clk) if (en3) ch3 <= {ch3[2:0], sd3};

    typedef struct {int cyc; logic b;} bit_e_t;
    typedef struct {int cyc; logic [3:0] chain; logic [2:0] cnt;} done_e_t;

    bit_e_t  bq0[$], bq1[$];
    done_e_t dq0[$], dq1[$];
    int      n_vec = 0, n_bad = 0;
    int      exp_d0 = 0, exp_d1 = 0, dcnt0 = 0, dcnt1 = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic mon_step(input int id, input logic en, input logic sd, input logic bz,
                            input logic dn, input logic [2:0] cnt, input logic [3:0] ch);
        bit_e_t  be;
        done_e_t de;
        int      nb, nd;
        nb = (id == 0) ? bq0.size() : bq1.size();
        nd = (id == 0) ? dq0.size() : dq1.size();
        if (en) begin
            if (nb == 0) begin
                chk($sformatf("dut%0d_spurious_shift", id), 32'(en), 0);
            end else begin
                if (id == 0) be = bq0.pop_front(); else be = bq1.pop_front();
                chk($sformatf("dut%0d_bit_value", id), 32'(sd), 32'(be.b));
                chk($sformatf("dut%0d_bit_cycle", id), cyc, be.cyc);
                chk($sformatf("dut%0d_busy_shift", id), 32'(bz), 1);
            end
        end
        if (dn) begin
            if (id == 0) dcnt0++; else dcnt1++;
            if (nd == 0) begin
                chk($sformatf("dut%0d_spurious_done", id), 32'(dn), 0);
            end else begin
                if (id == 0) de = dq0.pop_front(); else de = dq1.pop_front();
                chk($sformatf("dut%0d_done_cycle", id), cyc, de.cyc);
                chk($sformatf("dut%0d_done_chain", id), 32'(ch), 32'(de.chain));
                chk($sformatf("dut%0d_done_bit_cnt", id), 32'(cnt), 32'(de.cnt));
            end
        end
    endtask

    // Monitor: pops and compares whenever a DUT presents a bit or a done pulse
    always @(negedge clk) begin
        if (reset) begin
            mon_step(0, en0, sd0, busy0, done0, cnt0, ch0);
            mon_step(1, en3, sd3, busy3, done3, cnt3, ch3);
        end
    end

    // Offer a word, wait for acceptance, and queue its expected serial bits and done
    task automatic send(input int id, input logic [3:0] w, input logic p, output int k);
        logic    ok;
        bit_e_t  be;
        done_e_t de;
        ok = 1'b0;
        @(negedge clk);
        if (id == 0) begin d0 = w; v0 = 1'b1; end else begin d3 = w; v3 = 1'b1; end
        for (int i = 0; i < 40; i++) begin
            if (((id == 0) ? rdy0 : rdy3) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk($sformatf("dut%0d_accept_in_bound", id), 32'(ok), 1);
        k = cyc + 1;
        for (int i = 0; i < 4; i++) begin
            be.cyc = k + i;
            be.b   = w[3-i];
            if (id == 0) bq0.push_back(be); else bq1.push_back(be);
        end
        if (NB == 5) begin
            be.cyc = k + 4;
            be.b   = p;
            if (id == 0) bq0.push_back(be); else bq1.push_back(be);
        end
        de.cyc   = k + NB;
        de.chain = (NB == 5) ? {w[2:0], p} : w;
        de.cnt   = 3'(NB);
        if (id == 0) begin dq0.push_back(de); exp_d0++; end
        else begin dq1.push_back(de); exp_d1++; end
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg(input int t);
        do @(negedge clk); while (cyc < t);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k1, k2, d;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(rdy0), 1);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_sr_en", 32'(en0), 0);
        chk("rst_sr_d", 32'(sd0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_bit_cnt", 32'(cnt0), 0);
        chk("rst_in_ready_gap", 32'(rdy3), 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_in_ready", 32'(rdy0), 1);

        // Single word 1011, single-cycle valid
        send(0, 4'b1011, 1'b1, k);
        v0 = 1'b0;
        at_neg(k + NB);
        chk("ready_with_done", 32'(rdy0), 1);
        chk("idle_busy_after_done", 32'(busy0), 0);
        at_neg(k + NB + 1);
        chk("bit_cnt_holds", 32'(cnt0), 32'(NB));

        // Back-to-back A then 5 with valid held high
        send(0, 4'hA, 1'b0, k1);
        send(0, 4'h5, 1'b0, k2);
        v0 = 1'b0;
        chk("b2b_period", k2 - k1, NB + 1);
        at_neg(k2 + NB + 2);

        // Valid toggling and data changing while busy
        send(0, 4'b0110, 1'b0, k);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v0 = (i % 2 == 0) && (i < 3);
            d0 = 4'(i * 5 + 3);
        end
        at_neg(k + NB + 2);

        // GAP=3: in_ready held low after done, a valid pulse there is ignored
        send(1, 4'b1101, 1'b1, k);
        v3 = 1'b0;
        d  = k + NB;
        at_neg(d);
        chk("gap_ready_c0", 32'(rdy3), 0);
        at_neg(d + 1);
        chk("gap_ready_c1", 32'(rdy3), 0);
        v3 = 1'b1;
        d3 = 4'hF;
        at_neg(d + 2);
        chk("gap_ready_c2", 32'(rdy3), 0);
        v3 = 1'b0;
        at_neg(d + 3);
        chk("gap_ready_back", 32'(rdy3), 1);
        chk("gap_bit_cnt_holds", 32'(cnt3), 32'(NB));
        repeat (6) @(negedge clk);

        // Reset asserted mid-word abandons it without done
        send(0, 4'b1100, 1'b0, k);
        v0 = 1'b0;
        at_neg(k + 2);
        #1;
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_sr_en", 32'(en0), 0);
        chk("midrst_bit_cnt", 32'(cnt0), 0);
        chk("midrst_in_ready", 32'(rdy0), 1);
        bq0.delete();
        dq0.delete();
        exp_d0--;
        @(negedge clk);
        chk("midrst_no_done", 32'(done0), 0);
        reset = 1'b1;
        send(0, 4'b0011, 1'b0, k);
        v0 = 1'b0;
        at_neg(k + NB + 2);

`ifdef SHIFT_PARITY_EN
        // Parity trailer: 1011 -> 1, 1001 -> 0
        send(0, 4'b1011, 1'b1, k1);
        send(0, 4'b1001, 1'b0, k2);
        v0 = 1'b0;
        chk("par_period", k2 - k1, 6);
        at_neg(k2 + NB + 2);
`endif

        repeat (10) @(negedge clk);
        chk("drain_bits0", bq0.size(), 0);
        chk("drain_bits1", bq1.size(), 0);
        chk("drain_done0", dq0.size(), 0);
        chk("drain_done1", dq1.size(), 0);
        chk("done_count0", dcnt0, exp_d0);
        chk("done_count1", dcnt1, exp_d1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
